// File: rtl/dcache_miss_ctrl.sv
// Data-cache sequencer: forwards CPU requests to the cache, refills read misses from
// DRAM and writes every store through to DRAM via a single-entry write buffer.
module dcache_miss_ctrl #(
  parameter int MEM_SCALE = 27
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           cpu_oe,
  input  logic [MEM_SCALE-1:0] cpu_addr,
  input  logic [31:0]          cpu_wdata,
  input  logic [3:0]           cpu_we,
  output logic                 cpu_stall,
  output logic                 cpu_rvalid,
  output logic [31:0]          cpu_rdata,
  output logic [3:0]           cache_oe,
  output logic [3:0]           cache_we,
  input  logic                 cache_hit,
  input  logic [31:0]          cache_rdata,
  output logic                 load_oe,
  output logic [MEM_SCALE-1:0] load_addr,
  output logic [31:0]          load_wdata,
  output logic [3:0]           load_we,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [MEM_SCALE-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_wmask,
  input  logic                 mem_ack,
  input  logic                 mem_rvalid,
  input  logic [31:0]          mem_rdata,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_MREQ  = 3'd2,
    S_MWAIT = 3'd3,
    S_FILL  = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t                 r_state;
  logic                   r_prev_oe;
  logic [MEM_SCALE-1:0]   r_ld_addr;
  logic [31:0]            r_fill_data;
  logic                   r_wb_full;
  logic [MEM_SCALE-1:0]   r_wb_addr;
  logic [31:0]            r_wb_data;
  logic [3:0]             r_wb_mask;

  logic                   w_idle;
  logic                   w_miss;
  logic                   w_wb_issue;
  logic                   w_drain_now;
  logic                   w_stall;
  logic                   w_ld_accept;
  logic                   w_st_accept;
  logic [1:0]             w_shift;
  logic [3:0]             w_st_mask;
  logic [31:0]            w_st_data;

  // Handshakes: a CPU request transfers when its valid bit (oe[0]/we[0]) is high and
  // cpu_stall is low; a DRAM request transfers when mem_req and mem_ack are both high.
  assign w_idle      = (r_state == S_IDLE);
  assign w_miss      = r_prev_oe & ~cache_hit;
  assign w_wb_issue  = r_wb_full & (w_idle | (r_state == S_DRAIN));
  assign w_drain_now = w_wb_issue & mem_ack;
  assign w_stall     = w_miss | ~w_idle | (cpu_we[0] & r_wb_full & ~w_drain_now);
  assign w_ld_accept = cpu_oe[0] & ~w_stall;
  assign w_st_accept = cpu_we[0] & ~w_stall;
  assign w_shift     = cpu_addr[1:0];
  assign w_st_mask   = cpu_we << w_shift;
  assign w_st_data   = cpu_wdata << {w_shift, 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_prev_oe   <= 1'b0;
      r_ld_addr   <= '0;
      r_fill_data <= '0;
      r_wb_full   <= 1'b0;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
      r_wb_mask   <= '0;
    end else begin
      r_prev_oe <= w_ld_accept;
      if (w_ld_accept) r_ld_addr <= {cpu_addr[MEM_SCALE-1:2], 2'b00};
      // A store accepted in the drain cycle refills the buffer it just emptied.
      if (w_st_accept) begin
        r_wb_full <= 1'b1;
        r_wb_addr <= {cpu_addr[MEM_SCALE-1:2], 2'b00};
        r_wb_data <= w_st_data;
        r_wb_mask <= w_st_mask;
      end else if (w_drain_now) begin
        r_wb_full <= 1'b0;
      end
      case (r_state)
        S_IDLE:  if (w_miss) r_state <= (r_wb_full & ~w_drain_now) ? S_DRAIN : S_MREQ;
        S_DRAIN: if (~r_wb_full | w_drain_now) r_state <= S_MREQ;
        S_MREQ:  if (mem_ack) r_state <= S_MWAIT;
        S_MWAIT: if (mem_rvalid) begin
          r_fill_data <= mem_rdata;
          r_state     <= S_FILL;
        end
        S_FILL:  r_state <= S_RESP;
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_stall  = w_stall;
    cache_oe   = cpu_oe & {4{~w_stall}};
    cache_we   = cpu_we & {4{~w_stall}};
    cpu_rvalid = 1'b0;
    cpu_rdata  = '0;
    if (r_state == S_RESP) begin
      cpu_rvalid = 1'b1;
      cpu_rdata  = r_fill_data;
    end else if (r_prev_oe & cache_hit) begin
      cpu_rvalid = 1'b1;
      cpu_rdata  = cache_rdata;
    end
    load_oe    = (r_state == S_FILL);
    load_addr  = load_oe ? r_ld_addr : '0;
    load_wdata = load_oe ? r_fill_data : '0;
    load_we    = load_oe ? 4'hF : 4'h0;
    mem_req    = w_wb_issue | (r_state == S_MREQ);
    mem_we     = w_wb_issue;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wmask  = '0;
    if (w_wb_issue) begin
      mem_addr  = r_wb_addr;
      mem_wdata = r_wb_data;
      mem_wmask = r_wb_mask;
    end else if (r_state == S_MREQ) begin
      mem_addr = r_ld_addr;
    end
    dbg_state  = r_state;
  end

endmodule
